univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-002 Parameter: WIDTH, default 4, register length in bits; legal range 2..64.
REQ-003 Derived width: CW = $clog2(WIDTH+1), the width of the count output.
REQ-004 Port clk  in  1  rising-edge clock for all state.
REQ-005 Port rst  in  1  synchronous active-high reset.
REQ-006 Port en  in  1  clock enable; when low, all state holds.
REQ-007 Port mode  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 Port sin_r  in  1  serial input, enters the MSB on a right shift.
REQ-009 Port sin_l  in  1  serial input, enters the LSB on a left shift.
REQ-010 Port pdata  in  WIDTH  parallel load data.
REQ-011 Port q  out  WIDTH  parallel register contents.
REQ-012 Port sout_r  out  1  serial output for right shift; equals q[0].
REQ-013 Port sout_l  out  1  serial output for left shift; equals q[WIDTH-1].
REQ-014 Port cnt  out  CW  number of shifts since the last load or reset, saturating at WIDTH.
REQ-015 Port done  out  1  level, high when cnt == WIDTH, meaning a full frame has been shifted.

Function
REQ-016 All state (q, cnt) SHALL update only on the rising edge of clk; sout_r, sout_l and done SHALL be combinational decodes of registered state.
REQ-017 With en=1 and mode=01, q SHALL become {sin_r, q[WIDTH-1:1]} at the next edge (one-cycle latency).
REQ-018 With en=1 and mode=10, q SHALL become {q[WIDTH-2:0], sin_l} at the next edge.
REQ-019 With en=1 and mode=11, q SHALL become pdata at the next edge, and cnt SHALL become 0.
REQ-020 With en=1 and mode=00, q and cnt SHALL hold.
REQ-021 With en=0, q and cnt SHALL hold regardless of mode and data inputs.
REQ-022 Each shift (mode 01 or 10 with en=1) SHALL increment cnt by 1 if cnt < WIDTH; otherwise cnt SHALL hold at WIDTH.
REQ-023 Shifting while cnt == WIDTH SHALL still move q; only cnt saturates.
REQ-024 A direction change mid-frame (01 then 10) SHALL NOT reset cnt; each shift counts.
REQ-025 In mode 01 with WIDTH=4, a bit presented on sin_r SHALL appear on sout_r exactly WIDTH edges later, matching the four-stage serial-in/serial-out behaviour.
REQ-026 No input combination SHALL produce X on any output after the first reset.

Reset
REQ-027 When rst=1 at a rising edge, q SHALL become all zeros and cnt SHALL become 0, so sout_r=0, sout_l=0 and done=0.
REQ-028 rst SHALL take priority over en and every mode, including a simultaneous load or shift.
REQ-029 A reset asserted mid-frame SHALL discard the partial frame; the next frame starts at cnt=0.

Verification (WIDTH=4)
REQ-030 Reset: q=1010, cnt=2, rst=1 for one edge -> q=0000, cnt=0, done=0.
REQ-031 Right shift: from reset, en=1, mode=01, sin_r=1,0,1,1 over 4 edges -> q=1000,0100,1010,1101; then sout_r=1, cnt=4, done=1.
REQ-032 Load and left shift: mode=11, pdata=1001 -> q=1001, cnt=0; then mode=10, sin_l=0 for 2 edges -> q=0010 then 0100, sout_l=0 after the first edge, cnt=2, done=0.
REQ-033 Enable gating: q=0110, en=0, mode=11, pdata=1111 for 3 edges -> q=0110 and cnt unchanged.
REQ-034 Saturation: after a load, 6 right shifts with sin_r=1 -> q=1111, cnt=4 from edge 4 onward, done=1; then a load of 0000 -> cnt=0, done=0.
REQ-035 Priority: rst=1 together with en=1, mode=11, pdata=1111 -> q=0000, cnt=0.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with hold, right/left shift and parallel load,
// plus a saturating count of shifts since the last load or reset.
module univ_shift_reg #(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    cnt,
    output logic             done
);
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             shift, load, full;
    always_comb begin
        shift = en && (mode == 2'b01 || mode == 2'b10);
        load  = en && mode == 2'b11;
        full  = cnt_q == CW'(WIDTH);
        q_d   = !en ? q_q :
                mode == 2'b01 ? {sin_r, q_q[WIDTH-1:1]} :
                mode == 2'b10 ? {q_q[WIDTH-2:0], sin_l} :
                mode == 2'b11 ? pdata : q_q;
        // shifting past a full frame keeps moving data but the count sticks at WIDTH
        cnt_d = load ? '0 : (shift && !full) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end
    assign q      = q_q;
    assign cnt    = cnt_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];
    assign done   = full;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed vectors with hand-computed expectations for WIDTH=4.
module tb_univ_shift_reg;
    logic       clk = 0, rst = 0, en = 0, sin_r = 0, sin_l = 0;
    logic [1:0] mode = 0;
    logic [3:0] pdata = 0;
    logic [3:0] q;
    logic       sout_r, sout_l, done;
    logic [2:0] cnt;
    int         total = 0, bad = 0;
    logic [3:0] e;

    univ_shift_reg #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .pdata(pdata), .q(q), .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic n, input logic [1:0] m,
                         input logic sr, input logic sl, input logic [3:0] pd);
        rst = r; en = n; mode = m; sin_r = sr; sin_l = sl; pdata = pd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rbits;
        rbits = 4'b1101;
        drive(1, 0, 2'b00, 0, 0, 4'h0);
        chk("rst_q", q, 4'h0);
        chk("rst_cnt", cnt, 0);
        // build q=1010, cnt=2 then reset
        drive(0, 1, 2'b11, 0, 0, 4'b1000);
        drive(0, 1, 2'b01, 0, 0, 4'h0);
        drive(0, 1, 2'b01, 1, 0, 4'h0);
        chk("pre_q", q, 4'b1010);
        chk("pre_cnt", cnt, 2);
        drive(1, 0, 2'b00, 0, 0, 4'h0);
        chk("r030_q", q, 4'h0);
        chk("r030_cnt", cnt, 0);
        chk("r030_done", done, 0);
        chk("r030_souts", {sout_l, sout_r}, 0);
        // right shift 1,0,1,1
        drive(0, 1, 2'b01, 1, 0, 4'h0); chk("r031_q1", q, 4'b1000);
        drive(0, 1, 2'b01, 0, 0, 4'h0); chk("r031_q2", q, 4'b0100);
        chk("r031_done_mid", done, 0);
        drive(0, 1, 2'b01, 1, 0, 4'h0); chk("r031_q3", q, 4'b1010);
        drive(0, 1, 2'b01, 1, 0, 4'h0); chk("r031_q4", q, 4'b1101);
        chk("r031_sout_r", sout_r, rbits[0]);
        chk("r031_cnt", cnt, 4);
        chk("r031_done", done, 1);
        // load and left shift
        drive(0, 1, 2'b11, 0, 0, 4'b1001);
        chk("r032_ld_q", q, 4'b1001);
        chk("r032_ld_cnt", cnt, 0);
        drive(0, 1, 2'b10, 0, 0, 4'h0);
        chk("r032_q1", q, 4'b0010);
        chk("r032_sout_l", sout_l, 0);
        drive(0, 1, 2'b10, 0, 0, 4'h0);
        chk("r032_q2", q, 4'b0100);
        chk("r032_cnt", cnt, 2);
        chk("r032_done", done, 0);
        // mode 00 hold
        drive(0, 1, 2'b00, 1, 1, 4'hF);
        chk("hold_q", q, 4'b0100);
        chk("hold_cnt", cnt, 2);
        // enable gating
        drive(0, 1, 2'b11, 0, 0, 4'b0110);
        drive(0, 1, 2'b01, 1, 0, 4'h0);
        chk("gate_pre_q", q, 4'b1011);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, (i == 1) ? 2'b10 : 2'b11, 1, 1, 4'hF);
            chk("r033_q", q, 4'b1011);
            chk("r033_cnt", cnt, 1);
        end
        // direction change keeps counting
        drive(0, 1, 2'b10, 0, 1, 4'h0);
        chk("r024_q", q, 4'b0111);
        chk("r024_cnt", cnt, 2);
        // saturation
        drive(0, 1, 2'b11, 0, 0, 4'b0000);
        e = 4'h0;
        for (int k = 1; k <= 6; k++) begin
            drive(0, 1, 2'b01, 1, 0, 4'h0);
            e = {1'b1, e[3:1]};
            chk("r034_q", q, e);
            chk("r034_cnt", cnt, (k < 4) ? k : 4);
            chk("r034_done", done, k >= 4);
        end
        chk("r034_q_final", q, 4'b1111);
        // shifting at saturation still moves data
        drive(0, 1, 2'b01, 0, 0, 4'h0);
        chk("r023_q", q, 4'b0111);
        chk("r023_cnt", cnt, 4);
        drive(0, 1, 2'b11, 0, 0, 4'b0000);
        chk("r034_ld_cnt", cnt, 0);
        chk("r034_ld_done", done, 0);
        // mid-frame reset discards the partial frame
        drive(0, 1, 2'b01, 1, 0, 4'h0);
        drive(0, 1, 2'b01, 1, 0, 4'h0);
        drive(1, 1, 2'b01, 1, 0, 4'h0);
        chk("r029_rst_q", q, 4'h0);
        chk("r029_rst_cnt", cnt, 0);
        drive(0, 1, 2'b01, 1, 0, 4'h0);
        chk("r029_cnt", cnt, 1);
        chk("r029_q", q, 4'b1000);
        // reset beats load
        drive(1, 1, 2'b11, 0, 0, 4'b1111);
        chk("r035_q", q, 4'h0);
        chk("r035_cnt", cnt, 0);
        chk("r035_souts", {sout_l, sout_r, done}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
